decode_cycle: RTL and testbench

//  Decode stage of the 5-stage RV32I pipeline. Consumes the IF/ID outputs of the fetch stage (InstrD, PCD, PCPlus4D).

---
 rtl/riscv_pkg.sv | 52 +++++
 rtl/decode_cycle_if.sv | 45 ++++
 rtl/decode_reg_file.sv | 49 ++++
 rtl/decode_cycle.sv | 159 +++++++++++++++
 tb/tb_decode_cycle.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes and control-field encodings used by the decode stage.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpIAlu   = 7'b0010011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    typedef enum logic [1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10
    } alu_op_e;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOr  = 3'b011,
        AluSlt = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ImmI = 2'b00,
        ImmS = 2'b01,
        ImmB = 2'b10,
        ImmJ = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        ResAlu = 2'b00,
        ResMem = 2'b01,
        ResPc4 = 2'b10
    } result_src_e;

    typedef struct packed {
        logic        reg_write;
        imm_src_e    imm_src;
        logic        alu_src;
        logic        mem_write;
        result_src_e result_src;
        logic        branch;
        alu_op_e     alu_op;
        logic        jump;
    } ctrl_t;

endpackage

// File: rtl/decode_cycle_if.sv
// Decode-stage bus: IF/ID inputs, WB write-back, flush, and the ID/EX register outputs.
// master drives the stage inputs; slave is the decode stage itself.
interface decode_cycle_if;
    import riscv_pkg::*;

    logic [XLEN-1:0]       InstrD;
    logic [XLEN-1:0]       PCD;
    logic [XLEN-1:0]       PCPlus4D;
    logic                  RegWriteW;
    logic [REG_ADDR_W-1:0] RDW;
    logic [XLEN-1:0]       ResultW;
    logic                  FlushE;

    logic [REG_ADDR_W-1:0] RS1D;
    logic [REG_ADDR_W-1:0] RS2D;

    logic                  RegWriteE;
    logic                  MemWriteE;
    logic                  ALUSrcE;
    logic                  BranchE;
    logic                  JumpE;
    logic [1:0]            ResultSrcE;
    logic [2:0]            ALUControlE;
    logic [XLEN-1:0]       RD1E;
    logic [XLEN-1:0]       RD2E;
    logic [XLEN-1:0]       ImmExtE;
    logic [XLEN-1:0]       PCE;
    logic [XLEN-1:0]       PCPlus4E;
    logic [REG_ADDR_W-1:0] RDE;
    logic [REG_ADDR_W-1:0] RS1E;
    logic [REG_ADDR_W-1:0] RS2E;

    modport master (
        output InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
        input  RS1D, RS2D, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, ResultSrcE,
               ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RDE, RS1E, RS2E
    );

    modport slave (
        input  InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
        output RS1D, RS2D, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, ResultSrcE,
               ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RDE, RS1E, RS2E
    );

endinterface

// File: rtl/decode_reg_file.sv
// 32x32 register file: two async read ports, one sync write port, x0 hardwired to zero.
// Macro DECODE_WB_BYPASS_EN: a read hitting the register being written returns the write data.
module decode_reg_file
    import riscv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] i_raddr1,
    input  logic [REG_ADDR_W-1:0] i_raddr2,
    output logic [XLEN-1:0]       o_rdata1,
    output logic [XLEN-1:0]       o_rdata2,
    input  logic                  i_we,
    input  logic [REG_ADDR_W-1:0] i_waddr,
    input  logic [XLEN-1:0]       i_wdata
);

    // x0 has no storage.
    logic [XLEN-1:0] r_regs [1:31];
    logic            w_hit1;
    logic            w_hit2;

`ifdef DECODE_WB_BYPASS_EN
    assign w_hit1 = i_we && (i_raddr1 == i_waddr);
    assign w_hit2 = i_we && (i_raddr2 == i_waddr);
`else
    assign w_hit1 = 1'b0;
    assign w_hit2 = 1'b0;
`endif

    // Write port; reset clears the array without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Read ports; x0 check first so a bypass can never leak a write to x0.
    always_comb begin
        o_rdata1 = '0;
        o_rdata2 = '0;
        if (i_raddr1 != '0) o_rdata1 = w_hit1 ? i_wdata : r_regs[i_raddr1];
        if (i_raddr2 != '0) o_rdata2 = w_hit2 ? i_wdata : r_regs[i_raddr2];
    end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: main/ALU decoders, immediate extender, register-file read and ID/EX register.
// Optional macro DECODE_WB_BYPASS_EN enables write-first reads in decode_reg_file.
module decode_cycle
    import riscv_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    decode_cycle_if.slave  bus
);

    logic [6:0]      w_op;
    logic [2:0]      w_funct3;
    logic            w_funct7b5;
    logic [31:0]     w_instr;
    ctrl_t           w_ctrl;
    ctrl_t           w_ctrl_e;
    alu_ctrl_e       w_alu_ctrl;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;

    logic            r_reg_write;
    logic            r_mem_write;
    logic            r_alu_src;
    logic            r_branch;
    logic            r_jump;
    logic [1:0]      r_result_src;
    logic [2:0]      r_alu_ctrl;
    logic [XLEN-1:0] r_rd1;
    logic [XLEN-1:0] r_rd2;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc4;
    logic [4:0]      r_rd;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;

    assign w_instr    = bus.InstrD;
    assign w_op       = w_instr[6:0];
    assign w_funct3   = w_instr[14:12];
    assign w_funct7b5 = w_instr[30];
    assign bus.RS1D   = w_instr[19:15];
    assign bus.RS2D   = w_instr[24:20];

    // Main decoder: opcode to control bundle; unknown opcodes become a NOP.
    always_comb begin
        w_ctrl = '0;
        case (w_op)
            OpLoad:   w_ctrl = ctrl_t'{1'b1, ImmI, 1'b1, 1'b0, ResMem, 1'b0, AluOpAdd, 1'b0};
            OpStore:  w_ctrl = ctrl_t'{1'b0, ImmS, 1'b1, 1'b1, ResAlu, 1'b0, AluOpAdd, 1'b0};
            OpRType:  w_ctrl = ctrl_t'{1'b1, ImmI, 1'b0, 1'b0, ResAlu, 1'b0, AluOpFunct, 1'b0};
            OpBranch: w_ctrl = ctrl_t'{1'b0, ImmB, 1'b0, 1'b0, ResAlu, 1'b1, AluOpSub, 1'b0};
            OpIAlu:   w_ctrl = ctrl_t'{1'b1, ImmI, 1'b1, 1'b0, ResAlu, 1'b0, AluOpFunct, 1'b0};
            OpJal:    w_ctrl = ctrl_t'{1'b1, ImmJ, 1'b0, 1'b0, ResPc4, 1'b0, AluOpAdd, 1'b1};
            default:  w_ctrl = '0;
        endcase
    end

    // ALU decoder; sub only for R-type with funct7[5] set (I-type addi never subtracts).
    always_comb begin
        w_alu_ctrl = AluAdd;
        case (w_ctrl.alu_op)
            AluOpSub: w_alu_ctrl = AluSub;
            AluOpFunct: begin
                case (w_funct3)
                    3'b000:  w_alu_ctrl = (w_op[5] && w_funct7b5) ? AluSub : AluAdd;
                    3'b010:  w_alu_ctrl = AluSlt;
                    3'b110:  w_alu_ctrl = AluOr;
                    3'b111:  w_alu_ctrl = AluAnd;
                    default: w_alu_ctrl = AluAdd;
                endcase
            end
            default:  w_alu_ctrl = AluAdd;
        endcase
    end

    // Immediate extender, sign always taken from instr[31].
    always_comb begin
        w_imm = '0;
        unique case (w_ctrl.imm_src)
            ImmI: w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
            ImmS: w_imm = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
            ImmB: w_imm = {{20{w_instr[31]}}, w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
            ImmJ: w_imm = {{12{w_instr[31]}}, w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
        endcase
    end

    // Flush turns the captured entry into a bubble by zeroing its controls only.
    always_comb begin
        w_ctrl_e = w_ctrl;
        if (bus.FlushE) w_ctrl_e = '0;
    end

    decode_reg_file u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .i_raddr1 (w_instr[19:15]),
        .i_raddr2 (w_instr[24:20]),
        .o_rdata1 (w_rd1),
        .o_rdata2 (w_rd2),
        .i_we     (bus.RegWriteW),
        .i_waddr  (bus.RDW),
        .i_wdata  (bus.ResultW)
    );

    // ID/EX pipeline register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_alu_src    <= 1'b0;
            r_branch     <= 1'b0;
            r_jump       <= 1'b0;
            r_result_src <= '0;
            r_alu_ctrl   <= '0;
            r_rd1        <= '0;
            r_rd2        <= '0;
            r_imm        <= '0;
            r_pc         <= '0;
            r_pc4        <= '0;
            r_rd         <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
        end else begin
            r_reg_write  <= w_ctrl_e.reg_write;
            r_mem_write  <= w_ctrl_e.mem_write;
            r_alu_src    <= w_ctrl_e.alu_src;
            r_branch     <= w_ctrl_e.branch;
            r_jump       <= w_ctrl_e.jump;
            r_result_src <= w_ctrl_e.result_src;
            r_alu_ctrl   <= bus.FlushE ? 3'b000 : w_alu_ctrl;
            r_rd1        <= w_rd1;
            r_rd2        <= w_rd2;
            r_imm        <= w_imm;
            r_pc         <= bus.PCD;
            r_pc4        <= bus.PCPlus4D;
            r_rd         <= w_instr[11:7];
            r_rs1        <= w_instr[19:15];
            r_rs2        <= w_instr[24:20];
        end
    end

    assign bus.RegWriteE   = r_reg_write;
    assign bus.MemWriteE   = r_mem_write;
    assign bus.ALUSrcE     = r_alu_src;
    assign bus.BranchE     = r_branch;
    assign bus.JumpE       = r_jump;
    assign bus.ResultSrcE  = r_result_src;
    assign bus.ALUControlE = r_alu_ctrl;
    assign bus.RD1E        = r_rd1;
    assign bus.RD2E        = r_rd2;
    assign bus.ImmExtE     = r_imm;
    assign bus.PCE         = r_pc;
    assign bus.PCPlus4E    = r_pc4;
    assign bus.RDE         = r_rd;
    assign bus.RS1E        = r_rs1;
    assign bus.RS2E        = r_rs2;

endmodule

// File: tb/tb_decode_cycle.sv
// Self-checking bench for decode_cycle: directed cases plus randomized instructions against a
// table-driven reference model. Honours DECODE_WB_BYPASS_EN in its expectations.
module tb_decode_cycle;
    import riscv_pkg::*;

`ifdef DECODE_WB_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mdl_regs [32];

    typedef struct {
        logic [31:0] rw, mw, as, br, jp, rs, ac;
        logic [31:0] rd1, rd2, imm, pc, pc4, rd, rs1, rs2;
    } exp_t;

    always #5 clk = ~clk;

    decode_cycle_if dif ();

    decode_cycle u_dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Spec table row: {RegWrite, ImmSrc[1:0], ALUSrc, MemWrite, ResultSrc[1:0], Branch, ALUOp[1:0], Jump}
    function automatic logic [10:0] ctrl_row(input logic [6:0] op);
        case (op)
            7'b0000011: return 11'b1_00_1_0_01_0_00_0;
            7'b0100011: return 11'b0_01_1_1_00_0_00_0;
            7'b0110011: return 11'b1_00_0_0_00_0_10_0;
            7'b1100011: return 11'b0_10_0_0_00_1_01_0;
            7'b0010011: return 11'b1_00_1_0_00_0_10_0;
            7'b1101111: return 11'b1_11_0_0_10_0_00_1;
            default:    return 11'b0;
        endcase
    endfunction

    function automatic logic [31:0] mdl_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] rdw, input logic [31:0] resw);
        if (a == 5'd0) return 32'd0;
        if (Bypass && we && (a == rdw)) return resw;
        return mdl_regs[a];
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] pc4, input logic flush, input logic we,
                                   input logic [4:0] rdw, input logic [31:0] resw);
        exp_t        e;
        logic [10:0] row;
        logic [1:0]  isrc;
        logic [1:0]  aop;
        logic [31:0] sgn;
        row  = ctrl_row(ins[6:0]);
        isrc = row[9:8];
        aop  = row[2:1];
        sgn  = ($signed(ins) >>> 31);
        e.rw = {31'd0, row[10]};
        e.as = {31'd0, row[7]};
        e.mw = {31'd0, row[6]};
        e.rs = {30'd0, row[5:4]};
        e.br = {31'd0, row[3]};
        e.jp = {31'd0, row[0]};
        if (aop == 2'b01) e.ac = 32'd1;
        else if (aop == 2'b10) begin
            case (ins[14:12])
                3'b000:  e.ac = (ins[5] && ins[30]) ? 32'd1 : 32'd0;
                3'b010:  e.ac = 32'd5;
                3'b110:  e.ac = 32'd3;
                3'b111:  e.ac = 32'd2;
                default: e.ac = 32'd0;
            endcase
        end else e.ac = 32'd0;
        case (isrc)
            2'b00: e.imm = $signed(ins) >>> 20;
            2'b01: e.imm = (sgn << 12) | ((32'(ins) >> 20) & 32'hFE0) | 32'(ins[11:7]);
            2'b10: e.imm = (sgn << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5)
                           | (32'(ins[11:8]) << 1);
            default: e.imm = (sgn << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11)
                             | (32'(ins[30:21]) << 1);
        endcase
        if (flush) begin
            e.rw = 0; e.mw = 0; e.as = 0; e.br = 0; e.jp = 0; e.rs = 0; e.ac = 0;
        end
        e.rd1 = mdl_read(ins[19:15], we, rdw, resw);
        e.rd2 = mdl_read(ins[24:20], we, rdw, resw);
        e.pc  = pc;
        e.pc4 = pc4;
        e.rd  = 32'(ins[11:7]);
        e.rs1 = 32'(ins[19:15]);
        e.rs2 = 32'(ins[24:20]);
        return e;
    endfunction

    // Drive one cycle of inputs, clock it, then compare the ID/EX outputs with the model.
    task automatic step(input string tag, input logic [31:0] ins, input logic flush,
                        input logic we, input logic [4:0] rdw, input logic [31:0] resw);
        exp_t        e;
        logic [31:0] pc;
        pc            = $urandom & 32'hFFFF_FFFC;
        dif.InstrD    = ins;
        dif.PCD       = pc;
        dif.PCPlus4D  = pc + 32'd4;
        dif.FlushE    = flush;
        dif.RegWriteW = we;
        dif.RDW       = rdw;
        dif.ResultW   = resw;
        #1;
        check({tag, " RS1D"}, 32'(dif.RS1D), 32'(ins[19:15]));
        check({tag, " RS2D"}, 32'(dif.RS2D), 32'(ins[24:20]));
        e = model(ins, pc, pc + 32'd4, flush, we, rdw, resw);
        @(posedge clk);
        #1;
        if (we && rdw != 5'd0) mdl_regs[rdw] = resw;
        check({tag, " RegWriteE"},   32'(dif.RegWriteE),   e.rw);
        check({tag, " MemWriteE"},   32'(dif.MemWriteE),   e.mw);
        check({tag, " BranchE"},     32'(dif.BranchE),     e.br);
        check({tag, " JumpE"},       32'(dif.JumpE),       e.jp);
        check({tag, " ResultSrcE"},  32'(dif.ResultSrcE),  e.rs);
        check({tag, " ALUSrcE"},     32'(dif.ALUSrcE),     e.as);
        if (!flush) begin
            check({tag, " ALUControlE"}, 32'(dif.ALUControlE), e.ac);
            check({tag, " RD1E"},     dif.RD1E,       e.rd1);
            check({tag, " RD2E"},     dif.RD2E,       e.rd2);
            check({tag, " ImmExtE"},  dif.ImmExtE,    e.imm);
            check({tag, " PCE"},      dif.PCE,        e.pc);
            check({tag, " PCPlus4E"}, dif.PCPlus4E,   e.pc4);
            check({tag, " RDE"},      32'(dif.RDE),   e.rd);
            check({tag, " RS1E"},     32'(dif.RS1E),  e.rs1);
            check({tag, " RS2E"},     32'(dif.RS2E),  e.rs2);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " RegWriteE"},   32'(dif.RegWriteE),   32'd0);
        check({tag, " MemWriteE"},   32'(dif.MemWriteE),   32'd0);
        check({tag, " JumpE"},       32'(dif.JumpE),       32'd0);
        check({tag, " ALUControlE"}, 32'(dif.ALUControlE), 32'd0);
        check({tag, " RD1E"},        dif.RD1E,             32'd0);
        check({tag, " ImmExtE"},     dif.ImmExtE,          32'd0);
        check({tag, " PCE"},         dif.PCE,              32'd0);
        check({tag, " RDE"},         32'(dif.RDE),         32'd0);
    endtask

    initial begin
        logic [6:0]  ops [6];
        logic [31:0] ins;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011, 7'b1101111};
        for (int i = 0; i < 32; i++) mdl_regs[i] = 32'd0;
        dif.InstrD = '0; dif.PCD = '0; dif.PCPlus4D = '0;
        dif.RegWriteW = 1'b0; dif.RDW = '0; dif.ResultW = '0; dif.FlushE = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;

        // Write x5, then addi x6,x5,-1
        step("wr_x5", 32'h0000_0000, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        step("addi", 32'hFFF2_8313, 1'b0, 1'b0, 5'd0, 32'd0);
        check("addi RD1E const", dif.RD1E, 32'hDEAD_BEEF);
        check("addi ImmExtE const", dif.ImmExtE, 32'hFFFF_FFFF);
        check("addi RDE const", 32'(dif.RDE), 32'd6);
        check("addi ALUControlE const", 32'(dif.ALUControlE), 32'd0);

        // x0 write discarded
        step("wr_x0", 32'h0000_0000, 1'b0, 1'b1, 5'd0, 32'h0000_1234);
        step("rd_x0", 32'h0000_0313, 1'b0, 1'b0, 5'd0, 32'd0);
        check("x0 RD1E const", dif.RD1E, 32'd0);

        // beq and sw immediates
        step("beq", 32'hFE20_8CE3, 1'b0, 1'b0, 5'd0, 32'd0);
        check("beq ImmExtE const", dif.ImmExtE, 32'hFFFF_FFF8);
        check("beq BranchE const", 32'(dif.BranchE), 32'd1);
        check("beq ALUControlE const", 32'(dif.ALUControlE), 32'd1);
        step("sw", 32'h0020_A423, 1'b0, 1'b0, 5'd0, 32'd0);
        check("sw ImmExtE const", dif.ImmExtE, 32'd8);
        check("sw MemWriteE const", 32'(dif.MemWriteE), 32'd1);

        // Flushed lw becomes a bubble
        step("lw_flush", 32'h0000_2083, 1'b1, 1'b0, 5'd0, 32'd0);
        check("flush RegWriteE const", 32'(dif.RegWriteE), 32'd0);

        // Same-cycle WB write and read of x3
        step("wr_x3", 32'h0000_0000, 1'b0, 1'b1, 5'd3, 32'h1111_1111);
        step("wb_same", 32'h0001_8213, 1'b0, 1'b1, 5'd3, 32'hA5A5_A5A5);
        check("wb_same RD1E const", dif.RD1E, Bypass ? 32'hA5A5_A5A5 : 32'h1111_1111);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            int unsigned k;
            k   = $urandom_range(0, 6);
            ins = $urandom;
            ins[6:0] = (k < 6) ? ops[k] : 7'($urandom);
            step("rand", ins, ($urandom_range(0, 7) == 0), 1'($urandom), 5'($urandom),
                 $urandom);
        end

        // Asynchronous reset mid-run, away from any clock edge
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("midreset");
        for (int i = 0; i < 32; i++) mdl_regs[i] = 32'd0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int r = 1; r < 32; r++) begin
            ins = 32'h0000_0033 | (32'(r) << 15) | (32'(32 - r) << 20);
            step("postreset", ins, 1'b0, 1'b0, 5'd0, 32'd0);
            check("postreset RD1E const", dif.RD1E, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
